// File: rtl/raster_pkg.sv
// Shared constants and types for the rasterizer front end.
package raster_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 10;
   localparam int DEPTH_W  = 7;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [DEPTH_W-1:0] depth_t;

   // Last addressable pixel on each axis, in coordinate width.
   localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
   localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } scan_state_t;

   // Vertex data held for the whole scan of one triangle.
   typedef struct packed {
      coord_t ax;
      coord_t ay;
      coord_t bx;
      coord_t by;
      coord_t cx;
      coord_t cy;
      depth_t bz;
      depth_t cz;
   } tri_t;

endpackage

// File: rtl/minmax3.sv
// Unsigned minimum and maximum of three values.
module minmax3 #(
   parameter int W = 10
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] min_o,
   output logic [W-1:0] max_o
);

   logic [W-1:0] min_ab, max_ab;

   // Pairwise reduce a/b, then fold in c.
   always_comb begin
      min_ab = (a_i < b_i) ? a_i : b_i;
      max_ab = (a_i > b_i) ? a_i : b_i;
      min_o  = (c_i < min_ab) ? c_i : min_ab;
      max_o  = (c_i > max_ab) ? c_i : max_ab;
   end

endmodule

// File: rtl/bbox_scanner.sv
// Bounding-box scanner: latches a triangle, clamps its bounding box to the
// screen and walks every pixel of the box in raster order.
module bbox_scanner
   import raster_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   tri_valid,
   output logic   tri_ready,
   input  coord_t in_ax,
   input  coord_t in_ay,
   input  coord_t in_bx,
   input  coord_t in_by,
   input  coord_t in_cx,
   input  coord_t in_cy,
   input  depth_t in_bz,
   input  depth_t in_cz,
   output coord_t ax,
   output coord_t ay,
   output coord_t bx,
   output coord_t by,
   output coord_t cx,
   output coord_t cy,
   output depth_t bz,
   output depth_t cz,
   output coord_t x,
   output coord_t y,
   output logic   pix_valid,
   input  logic   pix_ready,
   output logic   pix_last,
   output logic   done
);

   scan_state_t state_q, state_d;
   tri_t        tri_q, tri_d;
   coord_t      minx_q, minx_d, maxx_q, maxx_d;
   coord_t      miny_q, miny_d, maxy_q, maxy_d;
   coord_t      x_q, x_d, y_q, y_d;
   logic        pv_q, pv_d;
   logic        done_q, done_d;

   coord_t      bb_minx, bb_maxx, bb_miny, bb_maxy;

   minmax3 #(.W(COORD_W)) u_mm_x (
      .a_i   (tri_q.ax),
      .b_i   (tri_q.bx),
      .c_i   (tri_q.cx),
      .min_o (bb_minx),
      .max_o (bb_maxx)
   );

   minmax3 #(.W(COORD_W)) u_mm_y (
      .a_i   (tri_q.ay),
      .b_i   (tri_q.by),
      .c_i   (tri_q.cy),
      .min_o (bb_miny),
      .max_o (bb_maxy)
   );

   // Next-state and datapath updates; everything holds unless a step fires.
   always_comb begin
      state_d = state_q;
      tri_d   = tri_q;
      minx_d  = minx_q;
      maxx_d  = maxx_q;
      miny_d  = miny_q;
      maxy_d  = maxy_q;
      x_d     = x_q;
      y_d     = y_q;
      pv_d    = pv_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tri_valid) begin
               tri_d   = '{ax: in_ax, ay: in_ay, bx: in_bx, by: in_by,
                           cx: in_cx, cy: in_cy, bz: in_bz, cz: in_cz};
               state_d = SETUP;
            end
         end
         SETUP: begin
            minx_d = bb_minx;
            miny_d = bb_miny;
            maxx_d = (bb_maxx > X_LAST) ? X_LAST : bb_maxx;
            maxy_d = (bb_maxy > Y_LAST) ? Y_LAST : bb_maxy;
            // A box starting past the screen edge has nothing to scan.
            if (bb_minx > X_LAST || bb_miny > Y_LAST) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               x_d     = bb_minx;
               y_d     = bb_miny;
               pv_d    = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (pix_ready) begin
               if (x_q != maxx_q) begin
                  x_d = x_q + coord_t'(1);
               end else begin
                  x_d = minx_q;
                  if (y_q != maxy_q) begin
                     y_d = y_q + coord_t'(1);
                  end else begin
                     pv_d    = 1'b0;
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Datapath registers; reset drops any triangle in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tri_q  <= '0;
         minx_q <= '0;
         maxx_q <= '0;
         miny_q <= '0;
         maxy_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         pv_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         tri_q  <= tri_d;
         minx_q <= minx_d;
         maxx_q <= maxx_d;
         miny_q <= miny_d;
         maxy_q <= maxy_d;
         x_q    <= x_d;
         y_q    <= y_d;
         pv_q   <= pv_d;
         done_q <= done_d;
      end
   end

   assign tri_ready = (state_q == IDLE);
   assign pix_valid = pv_q;
   assign pix_last  = pv_q && (x_q == maxx_q) && (y_q == maxy_q);
   assign done      = done_q;
   assign x         = x_q;
   assign y         = y_q;
   assign ax        = tri_q.ax;
   assign ay        = tri_q.ay;
   assign bx        = tri_q.bx;
   assign by        = tri_q.by;
   assign cx        = tri_q.cx;
   assign cy        = tri_q.cy;
   assign bz        = tri_q.bz;
   assign cz        = tri_q.cz;

endmodule
